// File: rtl/ppu_ram_palette.sv
// Pattern RAM (true dual-port, read-first, registered reads) plus a 32-entry palette
// with one write port and two enabled, registered read ports.
module ppu_ram_palette #(
  parameter int unsigned RAM_AW  = 12,
  parameter int unsigned RAM_DW  = 16,
  parameter int unsigned PAL_AW  = 5,
  parameter int unsigned COLOR_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [RAM_AW-1:0]  addr_a,
  input  logic [RAM_DW-1:0]  data_a,
  input  logic               we_a,
  output logic [RAM_DW-1:0]  q_a,
  input  logic [RAM_AW-1:0]  addr_b,
  input  logic [RAM_DW-1:0]  data_b,
  input  logic               we_b,
  output logic [RAM_DW-1:0]  q_b,
  input  logic [PAL_AW-1:0]  pal_addr_a,
  input  logic [PAL_AW-1:0]  pal_addr_b,
  input  logic               palette_en,
  output logic [COLOR_W-1:0] color_out_a,
  output logic [COLOR_W-1:0] color_out_b,
  input  logic               pal_we,
  input  logic [PAL_AW-1:0]  pal_wr_addr,
  input  logic [COLOR_W-1:0] pal_wr_data
);

  localparam int unsigned RamDepth = 2 ** RAM_AW;
  localparam int unsigned PalDepth = 2 ** PAL_AW;

  // Gray ramp level: low five bits of the index scaled into each 8-bit channel.
  function automatic logic [COLOR_W-1:0] gray_ramp(input int unsigned idx);
    logic [7:0] lvl;
    lvl = {idx[4:0], 3'b000};
    return COLOR_W'({3{lvl}});
  endfunction

  logic [RAM_DW-1:0]  mem_q [RamDepth];
  logic [RAM_DW-1:0]  q_a_d, q_a_q, q_b_d, q_b_q;
  logic [COLOR_W-1:0] pal_d [PalDepth];
  logic [COLOR_W-1:0] pal_q [PalDepth];
  logic [COLOR_W-1:0] color_a_d, color_a_q, color_b_d, color_b_q;

  always_comb begin
    q_a_d = mem_q[addr_a];
    q_b_d = mem_q[addr_b];
  end

  // Memory array is never reset; writes are simply blocked while reset is low.
  // Port B's write is issued last so it wins on an address collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_a_q <= '0;
      q_b_q <= '0;
    end else begin
      q_a_q <= q_a_d;
      q_b_q <= q_b_d;
      if (we_a) mem_q[addr_a] <= data_a;
      if (we_b) mem_q[addr_b] <= data_b;
    end
  end

  always_comb begin
    pal_d = pal_q;
    if (pal_we) pal_d[pal_wr_addr] = pal_wr_data;
  end

  always_comb begin
    color_a_d = color_a_q;
    color_b_d = color_b_q;
    if (palette_en) begin
      color_a_d = pal_q[pal_addr_a];
      color_b_d = pal_q[pal_addr_b];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PalDepth; i++) pal_q[i] <= gray_ramp(i);
      color_a_q <= '0;
      color_b_q <= '0;
    end else begin
      pal_q     <= pal_d;
      color_a_q <= color_a_d;
      color_b_q <= color_b_d;
    end
  end

  assign q_a         = q_a_q;
  assign q_b         = q_b_q;
  assign color_out_a = color_a_q;
  assign color_out_b = color_b_q;

endmodule

// File: tb/tb_ppu_ram_palette.sv
// Scoreboarded bench: each driven cycle pushes the model's expected outputs; a monitor
// pops and compares them just after every rising edge.
module tb_ppu_ram_palette;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] addr_a, addr_b;
  logic [15:0] data_a, data_b, q_a, q_b;
  logic        we_a, we_b;
  logic [4:0]  pal_addr_a, pal_addr_b, pal_wr_addr;
  logic        palette_en, pal_we;
  logic [23:0] color_out_a, color_out_b, pal_wr_data;

  ppu_ram_palette dut (
    .clk        (clk),
    .reset      (reset),
    .addr_a     (addr_a),
    .data_a     (data_a),
    .we_a       (we_a),
    .q_a        (q_a),
    .addr_b     (addr_b),
    .data_b     (data_b),
    .we_b       (we_b),
    .q_b        (q_b),
    .pal_addr_a (pal_addr_a),
    .pal_addr_b (pal_addr_b),
    .palette_en (palette_en),
    .color_out_a(color_out_a),
    .color_out_b(color_out_b),
    .pal_we     (pal_we),
    .pal_wr_addr(pal_wr_addr),
    .pal_wr_data(pal_wr_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] qa;
    logic [15:0] qb;
    logic [23:0] ca;
    logic [23:0] cb;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model state
  logic [15:0] m_mem [4096];
  logic [23:0] m_pal [32];
  exp_t        m_out;

  function automatic logic [23:0] gray(input int i);
    logic [7:0] g;
    g = 8'(i * 8);
    return {g, g, g};
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model one rising edge with the current inputs, queue the result, return at next negedge.
  task automatic step();
    exp_t e;
    if (!reset) begin
      e = '0;
      for (int i = 0; i < 32; i++) m_pal[i] = gray(i);
    end else begin
      e.qa = m_mem[addr_a];
      e.qb = m_mem[addr_b];
      e.ca = palette_en ? m_pal[pal_addr_a] : m_out.ca;
      e.cb = palette_en ? m_pal[pal_addr_b] : m_out.cb;
      if (we_a)   m_mem[addr_a] = data_a;
      if (we_b)   m_mem[addr_b] = data_b;
      if (pal_we) m_pal[pal_wr_addr] = pal_wr_data;
    end
    m_out = e;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    we_a = 0; we_b = 0; pal_we = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_q_a", 24'(q_a), 24'(e.qa));
        check("sb_q_b", 24'(q_b), 24'(e.qb));
        check("sb_color_a", color_out_a, e.ca);
        check("sb_color_b", color_out_b, e.cb);
      end
    end
  end

  initial begin : driver
    for (int i = 0; i < 4096; i++) m_mem[i] = '0;
    m_out = '0;
    reset = 0;
    addr_a = 0; addr_b = 0; data_a = 0; data_b = 0;
    pal_addr_a = 0; pal_addr_b = 0; pal_wr_addr = 0; pal_wr_data = 0;
    palette_en = 0;
    idle_inputs();
    #1;
    check("rst_q_a", 24'(q_a), 24'h0);
    check("rst_color_b", color_out_b, 24'h0);
    @(negedge clk);
    step();
    step();
    reset = 1;

    // Write through port A, same-cycle read returns old word; port B reads new word.
    we_a = 1; addr_a = 12'd16; data_a = 16'hA5C3;
    step();
    check("rd_first_q_a", 24'(q_a), 24'h0);
    idle_inputs(); addr_b = 12'd16;
    step();
    check("cross_q_b", 24'(q_b), 24'hA5C3);

    // Dual write collision: port B wins.
    we_a = 1; we_b = 1; addr_a = 12'd1000; addr_b = 12'd1000;
    data_a = 16'h1111; data_b = 16'h2222;
    step();
    idle_inputs(); addr_a = 12'd1000;
    step();
    check("collide_q_a", 24'(q_a), 24'h2222);

    // Preload 0..2, then stream back-to-back reads.
    for (int i = 0; i < 3; i++) begin
      we_a = 1; addr_a = 12'(i); data_a = 16'(i + 1);
      step();
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      addr_a = 12'(i);
      step();
      check("stream_q_a", 24'(q_a), 24'(i + 1));
    end

    // Palette write with same-cycle read of that entry.
    palette_en = 1; pal_addr_b = 5'd3;
    pal_we = 1; pal_wr_addr = 5'd3; pal_wr_data = 24'hFF0000;
    step();
    check("pal_old_b", color_out_b, 24'h181818);
    pal_we = 0;
    step();
    check("pal_new_b", color_out_b, 24'hFF0000);

    // Enable gating.
    pal_addr_a = 5'd2;
    step();
    check("pal_en_a", color_out_a, 24'h101010);
    palette_en = 0; pal_addr_a = 5'd4;
    step();
    check("pal_hold_a", color_out_a, 24'h101010);
    step();
    check("pal_hold2_a", color_out_a, 24'h101010);
    palette_en = 1;
    step();
    check("pal_reen_a", color_out_a, 24'h202020);

    // Mid-operation reset with writes attempted during it.
    reset = 0;
    #1;
    check("arst_q_a", 24'(q_a), 24'h0);
    check("arst_q_b", 24'(q_b), 24'h0);
    check("arst_color_a", color_out_a, 24'h0);
    check("arst_color_b", color_out_b, 24'h0);
    we_a = 1; addr_a = 12'd16; data_a = 16'hFFFF;
    pal_we = 1; pal_wr_addr = 5'd1; pal_wr_data = 24'h123456;
    step();
    reset = 1;
    idle_inputs(); pal_addr_a = 5'd1; palette_en = 1; addr_a = 12'd16;
    step();
    check("post_rst_color_a", color_out_a, 24'h080808);
    check("post_rst_mem_q_a", 24'(q_a), 24'hA5C3);
    pal_addr_b = 5'd3;
    step();
    check("post_rst_ramp_b", color_out_b, 24'h181818);

    // Randomized traffic, biased toward a few addresses so collisions occur.
    for (int n = 0; n < 1500; n++) begin
      reset       = ($urandom_range(0, 99) != 0);
      addr_a      = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 7));
      addr_b      = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 7));
      data_a      = 16'($urandom);
      data_b      = 16'($urandom);
      we_a        = 1'($urandom);
      we_b        = 1'($urandom);
      pal_addr_a  = 5'($urandom);
      pal_addr_b  = ($urandom_range(0, 3) == 0) ? pal_addr_a : 5'($urandom);
      palette_en  = ($urandom_range(0, 3) != 0);
      pal_we      = 1'($urandom);
      pal_wr_addr = ($urandom_range(0, 1) == 0) ? pal_addr_a : 5'($urandom);
      pal_wr_data = 24'($urandom);
      step();
      reset = 1;
    end

    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
